hazard_forward_unit: RTL and testbench

- Hazard-detection and forwarding controller for the 5-stage pipelined RISC-V core.
- Shadows the destination/source register fields through internal E/M/W tracking registers.
- Produces ForwardA_E/ForwardB_E, the select inputs of the execute-stage forwarding muxes; those muxes are the consumers of this block.
- Also produces load-use stall and branch flush controls, and keeps hazard event counters for CNN workload profiling.

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/hazard_forward_unit_sat_counter.sv | 22 ++
 rtl/hazard_forward_unit.sv | 112 +++++++++++
 tb/tb_hazard_forward_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the pipeline hazard/forwarding logic: forward-mux
// select encodings, register index width and the hard-wired zero register.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, holding once every bit is set
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage core: forward
// selects, load-use stall, branch flush and hazard event counters.
import riscv_pipe_pkg::*;

module hazard_forward_unit #(
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rd_D,
  input  logic                  RegWrite_D,
  input  logic                  Load_D,
  input  logic                  PCSrc_E,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E,
  output logic                  Stall_F,
  output logic                  Stall_D,
  output logic                  Flush_D,
  output logic                  Flush_E,
  output logic [CNT_W-1:0]      lw_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [REG_ADDR_W-1:0] rs1_e_r, rs2_e_r, rd_e_r, rd_m_r, rd_w_r;
  logic                  regwrite_e_r, load_e_r, regwrite_m_r, regwrite_w_r;
  logic                  lw_stall_s, flush_e_s;
  logic [CNT_W-1:0]      lw_cnt_s, flush_cnt_s;

  // M has priority over W; x0 is a constant and never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    if (we_m && (rd_m != X0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (we_w && (rd_w != X0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign lw_stall_s = load_e_r && (rd_e_r != X0) &&
                      ((rd_e_r == Rs1_D) || (rd_e_r == Rs2_D));
  assign flush_e_s  = lw_stall_s || PCSrc_E;

  // Shadow the register fields down the E/M/W stages; only E takes bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e_r <= X0; rs2_e_r <= X0; rd_e_r <= X0;
      regwrite_e_r <= 1'b0; load_e_r <= 1'b0;
      rd_m_r <= X0; regwrite_m_r <= 1'b0;
      rd_w_r <= X0; regwrite_w_r <= 1'b0;
    end else begin
      if (flush_e_s) begin
        rs1_e_r <= X0; rs2_e_r <= X0; rd_e_r <= X0;
        regwrite_e_r <= 1'b0; load_e_r <= 1'b0;
      end else begin
        rs1_e_r <= Rs1_D; rs2_e_r <= Rs2_D; rd_e_r <= Rd_D;
        regwrite_e_r <= RegWrite_D; load_e_r <= Load_D;
      end
      rd_m_r <= rd_e_r; regwrite_m_r <= regwrite_e_r;
      rd_w_r <= rd_m_r; regwrite_w_r <= regwrite_m_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_lw_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lw_stall_s),
    .count (lw_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (PCSrc_E),
    .count (flush_cnt_s)
  );

  // Reset overrides every output, including a pending branch flush
  always_comb begin
    ForwardA_E   = FWD_RF;
    ForwardB_E   = FWD_RF;
    Stall_F      = 1'b0;
    Stall_D      = 1'b0;
    Flush_D      = 1'b0;
    Flush_E      = 1'b0;
    lw_stall_cnt = {CNT_W{1'b0}};
    flush_cnt    = {CNT_W{1'b0}};
    if (rst) begin
      ForwardA_E = FWD_RF;
      ForwardB_E = FWD_RF;
    end else begin
      ForwardA_E   = fwd_sel(rs1_e_r, rd_m_r, regwrite_m_r, rd_w_r, regwrite_w_r);
      ForwardB_E   = fwd_sel(rs2_e_r, rd_m_r, regwrite_m_r, rd_w_r, regwrite_w_r);
      Stall_F      = lw_stall_s;
      Stall_D      = lw_stall_s;
      Flush_D      = PCSrc_E;
      Flush_E      = flush_e_s;
      lw_stall_cnt = lw_cnt_s;
      flush_cnt    = flush_cnt_s;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed pipeline scenarios plus random traffic,
// compared each cycle against an instruction-history reference model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rd_D;
  logic       RegWrite_D, Load_D, PCSrc_E;
  logic [1:0] ForwardA_E, ForwardB_E, fa_sat, fb_sat;
  logic       Stall_F, Stall_D, Flush_D, Flush_E;
  logic       sf_sat, sd_sat, fd_sat, fe_sat;
  logic [31:0] lw_stall_cnt, flush_cnt;
  logic [3:0]  lw_cnt4, flush_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .Load_D(Load_D), .PCSrc_E(PCSrc_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .lw_stall_cnt(lw_stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .Load_D(Load_D), .PCSrc_E(PCSrc_E),
    .ForwardA_E(fa_sat), .ForwardB_E(fb_sat),
    .Stall_F(sf_sat), .Stall_D(sd_sat), .Flush_D(fd_sat), .Flush_E(fe_sat),
    .lw_stall_cnt(lw_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       we, ld;
  } instr_t;

  // hist[0] is the instruction in E, hist[1] the one ahead of it, hist[2] two ahead
  instr_t      hist[3];
  longint      n_lw, n_flush;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    logic [1:0] f = 2'd0;
    for (int k = 2; k >= 1; k--) begin
      if (hist[k].we && hist[k].rd != 5'd0 && hist[k].rd == rs)
        f = (k == 1) ? 2'd2 : 2'd1;
    end
    return f;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx = (64'sd1 <<< w) - 64'sd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic pc, input logic r);
    logic   stall;
    instr_t nxt;
    @(negedge clk);
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd; RegWrite_D = we; Load_D = ld;
    PCSrc_E = pc; rst = r;
    #1;
    stall = hist[0].ld && hist[0].rd != 5'd0 && (hist[0].rd == rs1 || hist[0].rd == rs2);
    if (r) begin
      chk("rst_fwdA", {ForwardA_E, ForwardB_E, Stall_F, Stall_D, Flush_D, Flush_E}, 32'd0);
      chk("rst_cnt", lw_stall_cnt | flush_cnt, 32'd0);
      chk("rst_cnt4", {24'd0, lw_cnt4, flush_cnt4}, 32'd0);
    end else begin
      chk("fwdA", ForwardA_E, ref_fwd(rs1_e()));
      chk("fwdB", ForwardB_E, ref_fwd(hist[0].rs2));
      chk("stall", {Stall_F, Stall_D}, {stall, stall});
      chk("flush", {Flush_D, Flush_E}, {pc, stall | pc});
      chk("lw_cnt", lw_stall_cnt, 32'(sat(n_lw, 32)));
      chk("flush_cnt", flush_cnt, 32'(sat(n_flush, 32)));
      chk("lw_cnt4", lw_cnt4, 32'(sat(n_lw, 4)));
      chk("flush_cnt4", flush_cnt4, 32'(sat(n_flush, 4)));
    end
    nxt = '{rs1: rs1, rs2: rs2, rd: rd, we: we, ld: ld};
    if (r) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      n_lw = 0; n_flush = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (stall || pc) ? instr_t'('0) : nxt;
      n_lw    = n_lw + (stall ? 1 : 0);
      n_flush = n_flush + (pc ? 1 : 0);
    end
    last_stall = stall && !r;
  endtask

  function automatic logic [4:0] rs1_e();
    return hist[0].rs1;
  endfunction

  task automatic nop();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [4:0] a, b, d;
    logic       w, l;
    hist[0] = '0; hist[1] = '0; hist[2] = '0;
    n_lw = 0; n_flush = 0; last_stall = 1'b0;
    rst = 1'b1; PCSrc_E = 1'b0;
    Rs1_D = 5'd0; Rs2_D = 5'd0; Rd_D = 5'd0; RegWrite_D = 1'b0; Load_D = 1'b0;
    do_rst(); do_rst();
    nop();
    chk("reset_fwd", {ForwardA_E, ForwardB_E}, 32'd0);

    // add x5,x1,x2 ; sub x6,x5,x3
    step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    chk("alu_mem_fwdA", ForwardA_E, 32'd2);
    step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    step(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    chk("alu_wb_fwdA", ForwardA_E, 32'd1);

    // x7 written twice in a row, consumer reads it on rs2
    step(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    chk("double_fwdB", ForwardB_E, 32'd2);

    // write to x0 must not forward
    step(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    chk("x0_fwdA", ForwardA_E, 32'd0);

    // lw x4 ; add x8,x4,x9
    do_rst();
    step(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd4, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", {Stall_F, Stall_D, Flush_E}, 32'd7);
    step(5'd4, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_once", {Stall_F, Stall_D, Flush_E}, 32'd0);
    nop();
    chk("lu_fwdA", ForwardA_E, 32'd1);
    chk("lu_cnt", lw_stall_cnt, 32'd1);

    // taken branch squashes a load in D, so its consumer does not stall
    do_rst();
    step(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("br_flush", {Flush_D, Flush_E}, 32'd3);
    step(5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_e_cleared", Stall_F, 32'd0);
    chk("br_cnt1", flush_cnt, 32'd1);
    do_rst();
    for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nop();
    chk("br_cnt3", flush_cnt, 32'd3);

    // reset with a branch pending and a load-use hazard in flight
    step(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_outs", {Flush_D, Flush_E, Stall_F}, 32'd0);
    nop();
    chk("mid_rst_cnt", flush_cnt, 32'd0);
    chk("mid_rst_fwd", ForwardA_E, 32'd0);

    // 20 load-use pairs: narrow counters stop at 15
    for (int i = 0; i < 20; i++) begin
      step(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      step(5'd4, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      step(5'd4, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    nop();
    chk("sat_cnt4", lw_cnt4, 32'd15);
    chk("sat_cnt32", lw_stall_cnt, 32'd20);

    // random traffic, stalled decode instructions are held
    a = 5'd0; b = 5'd0; d = 5'd0; w = 1'b0; l = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        w = 1'($urandom_range(0, 3) != 0);
        l = w && ($urandom_range(0, 2) == 0);
      end
      step(a, b, d, w, l, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
